// File: rtl/svm_cascade_ctrl_pkg.sv
// rtl/svm_cascade_ctrl_pkg.sv - shared cascade constants and FSM state encoding
package svm_cascade_ctrl_pkg;

  localparam int          DEC_W_DEF   = 16;
  localparam int          LABEL_W_DEF = 4;
  localparam logic [15:0] THRESH_DEF  = 16'd256;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    S2_START = 3'd2,
    S2_WAIT  = 3'd3,
    OUT      = 3'd4
  } state_t;

endpackage

// File: rtl/svm_cascade_ctrl_sat_counter.sv
// rtl/svm_cascade_ctrl_sat_counter.sv - increment-enable counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/svm_cascade_ctrl.sv
// rtl/svm_cascade_ctrl.sv - two-stage SVM cascade: emit confident stage-1 results, escalate the rest
module svm_cascade_ctrl
  import svm_cascade_ctrl_pkg::*;
#(
  parameter int                 DEC_W     = DEC_W_DEF,
  parameter int                 LABEL_W   = LABEL_W_DEF,
  parameter logic [15:0]        THRESH    = THRESH_DEF,
  parameter logic [LABEL_W-1:0] POS_LABEL = LABEL_W'(1),
  parameter logic [LABEL_W-1:0] NEG_LABEL = LABEL_W'(0),
  parameter int                 TIMEOUT   = 4096,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s1_valid,
  input  logic [DEC_W-1:0]   s1_dec,
  output logic               s1_ready,
  output logic               s2_start,
  input  logic               s2_done,
  input  logic [LABEL_W-1:0] s2_class,
  output logic               out_valid,
  output logic [LABEL_W-1:0] out_class,
  output logic               out_src,
  output logic               out_timeout,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   cnt_total,
  output logic [CNT_W-1:0]   cnt_escalated
);

  localparam int              TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [DEC_W:0]  THRESH_X = (DEC_W+1)'(THRESH);

  state_t             state, state_nx;
  logic               dec_neg;
  logic [DEC_W:0]     mag_q;
  logic [DEC_W:0]     dec_ext;
  logic [DEC_W:0]     mag_in;
  logic [TW-1:0]      tcnt;
  logic               timeout_hit;
  logic               confident;
  logic [LABEL_W-1:0] sign_label;

  // One extra bit so the most negative decision value has an exact magnitude
  assign dec_ext     = {s1_dec[DEC_W-1], s1_dec};
  assign mag_in      = dec_ext[DEC_W] ? (~dec_ext + (DEC_W+1)'(1)) : dec_ext;
  assign confident   = (mag_q >= THRESH_X);
  assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));
  assign sign_label  = dec_neg ? NEG_LABEL : POS_LABEL;

  assign s1_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (s1_valid) state_nx = CHECK;
      CHECK:    state_nx = confident ? OUT : S2_START;
      S2_START: state_nx = S2_WAIT;
      S2_WAIT:  if (s2_done || timeout_hit) state_nx = OUT;
      OUT:      if (out_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_neg     <= 1'b0;
      mag_q       <= '0;
      tcnt        <= '0;
      s2_start    <= 1'b0;
      out_valid   <= 1'b0;
      out_class   <= '0;
      out_src     <= 1'b0;
      out_timeout <= 1'b0;
    end else begin
      s2_start <= (state_nx == S2_START);
      case (state)
        IDLE: begin
          if (s1_valid) begin
            dec_neg <= s1_dec[DEC_W-1];
            mag_q   <= mag_in;
          end
        end
        CHECK: begin
          if (confident) begin
            out_valid   <= 1'b1;
            out_class   <= sign_label;
            out_src     <= 1'b0;
            out_timeout <= 1'b0;
          end
        end
        S2_START: tcnt <= '0;
        S2_WAIT: begin
          tcnt <= tcnt + TW'(1);
          // A result arriving on the last allowed cycle still beats the timeout
          if (s2_done) begin
            out_valid   <= 1'b1;
            out_class   <= s2_class;
            out_src     <= 1'b1;
            out_timeout <= 1'b0;
          end else if (timeout_hit) begin
            out_valid   <= 1'b1;
            out_class   <= sign_label;
            out_src     <= 1'b0;
            out_timeout <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            out_timeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_total (
    .clk   (clk),
    .rst   (rst),
    .inc   ((state == OUT) && out_ready),
    .count (cnt_total)
  );

  sat_counter #(.W(CNT_W)) u_cnt_escalated (
    .clk   (clk),
    .rst   (rst),
    .inc   (state == S2_START),
    .count (cnt_escalated)
  );

endmodule

// File: tb/tb_svm_cascade_ctrl.sv
// tb/tb_svm_cascade_ctrl.sv - self-checking bench for the SVM cascade controller
module tb_svm_cascade_ctrl;

  localparam int TMO  = 16;
  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s1_valid = 1'b0;
  logic [15:0] s1_dec = '0;
  logic        s1_ready;
  logic        s2_start;
  logic        s2_done = 1'b0;
  logic [3:0]  s2_class = '0;
  logic        out_valid;
  logic [3:0]  out_class;
  logic        out_src;
  logic        out_timeout;
  logic        out_ready = 1'b1;
  logic        busy;
  logic [3:0]  cnt_total;
  logic [3:0]  cnt_escalated;

  int errors = 0;
  int checks = 0;
  int exp_total = 0;
  int exp_esc = 0;

  typedef struct {
    int lat; int n_start; logic [3:0] cls; logic src; logic tmo; bit esc;
  } exp_t;

  typedef struct {
    int lat; int n_start; int nvalid; logic [3:0] cls; logic src; logic tmo; bit stable; bit ok_after;
  } obs_t;

  svm_cascade_ctrl #(
    .DEC_W(16), .LABEL_W(4), .THRESH(16'd256), .POS_LABEL(4'd1), .NEG_LABEL(4'd0),
    .TIMEOUT(TMO), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .s1_valid(s1_valid), .s1_dec(s1_dec), .s1_ready(s1_ready),
    .s2_start(s2_start), .s2_done(s2_done), .s2_class(s2_class),
    .out_valid(out_valid), .out_class(out_class), .out_src(out_src), .out_timeout(out_timeout),
    .out_ready(out_ready), .busy(busy), .cnt_total(cnt_total), .cnt_escalated(cnt_escalated)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outcome of one image from the cascade rules; d = cycles after s2_start that s2_done is driven (<0: never)
  function automatic exp_t model(input int dec, input int d, input logic [3:0] s2c);
    exp_t e;
    int mag;
    logic [3:0] sl;
    mag = (dec < 0) ? -dec : dec;
    sl  = (dec < 0) ? 4'd0 : 4'd1;
    if (mag >= 256) begin
      e.lat = 2; e.n_start = 0; e.cls = sl; e.src = 1'b0; e.tmo = 1'b0; e.esc = 1'b0;
    end else if (d >= 1 && d <= TMO) begin
      e.lat = 2 + d + 1; e.n_start = 1; e.cls = s2c; e.src = 1'b1; e.tmo = 1'b0; e.esc = 1'b1;
    end else begin
      e.lat = 2 + TMO + 1; e.n_start = 1; e.cls = sl; e.src = 1'b0; e.tmo = 1'b1; e.esc = 1'b1;
    end
    return e;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; s1_valid = 1'b0; s2_done = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    exp_total = 0; exp_esc = 0;
  endtask

  task automatic run_image(input int dec, input int d, input logic [3:0] s2c, input int hold, output obs_t o);
    int cyc;
    int start_cyc;
    o.lat = -1; o.n_start = 0; o.nvalid = 0; o.stable = 1'b1; o.ok_after = 1'b0;
    o.cls = 'x; o.src = 1'bx; o.tmo = 1'bx;
    start_cyc = -1;
    s1_dec = 16'(dec); s1_valid = 1'b1; out_ready = (hold == 0);
    step();
    cyc = 1; s1_valid = 1'b0; s1_dec = 16'($urandom);
    while (!out_valid && cyc < 200) begin
      if (s2_start) begin
        o.n_start++;
        if (start_cyc < 0) start_cyc = cyc;
      end
      s2_done  = (start_cyc >= 0 && d >= 0 && cyc == start_cyc + d);
      s2_class = s2_done ? s2c : 4'($urandom);
      step();
      cyc++;
      s2_done = 1'b0;
    end
    if (!out_valid) return;
    o.lat = cyc; o.cls = out_class; o.src = out_src; o.tmo = out_timeout; o.nvalid = 1;
    if (s1_ready) o.stable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (out_valid) o.nvalid++;
      if (!out_valid || out_class !== o.cls || out_src !== o.src || out_timeout !== o.tmo || s1_ready)
        o.stable = 1'b0;
    end
    out_ready = 1'b1;
    step();
    o.ok_after = (!out_valid && s1_ready && !busy);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL reset_s1_ready got=%b want=1", s1_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (out_valid !== 1'b0 || s2_start !== 1'b0) begin errors++; $display("FAIL reset_valid_start got=%b%b want=00", out_valid, s2_start); end
    checks++; if (out_class !== 4'd0 || out_src !== 1'b0 || out_timeout !== 1'b0) begin errors++; $display("FAIL reset_out got=%0d/%b/%b want=0/0/0", out_class, out_src, out_timeout); end
    checks++; if (cnt_total !== 4'd0 || cnt_escalated !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", cnt_total, cnt_escalated); end
  endtask

  task automatic test_confident_pos();
    obs_t o; exp_t e;
    e = model(300, -1, 4'd0);
    run_image(300, -1, 4'd0, 0, o);
    exp_total = sat_inc(exp_total);
    checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL pos_latency got=%0d want=%0d", o.lat, e.lat); end
    checks++; if (o.cls !== e.cls || o.src !== e.src) begin errors++; $display("FAIL pos_class got=%0d/%b want=%0d/%b", o.cls, o.src, e.cls, e.src); end
    checks++; if (o.n_start !== 0) begin errors++; $display("FAIL pos_no_start got=%0d want=0", o.n_start); end
    checks++; if (!o.ok_after || cnt_total !== 4'(exp_total)) begin errors++; $display("FAIL pos_after got=%b/%0d want=1/%0d", o.ok_after, cnt_total, exp_total); end
  endtask

  task automatic test_confident_neg_backpressure();
    obs_t o; exp_t e;
    e = model(-32768, -1, 4'd0);
    run_image(-32768, -1, 4'd0, 5, o);
    exp_total = sat_inc(exp_total);
    checks++; if (o.cls !== e.cls || o.src !== 1'b0 || o.lat !== e.lat) begin errors++; $display("FAIL neg_class got=%0d/%b/%0d want=%0d/0/%0d", o.cls, o.src, o.lat, e.cls, e.lat); end
    checks++; if (!o.stable || o.nvalid !== 6) begin errors++; $display("FAIL neg_hold got stable=%b valid_cycles=%0d want 1/6", o.stable, o.nvalid); end
    checks++; if (cnt_total !== 4'(exp_total)) begin errors++; $display("FAIL neg_cnt_total got=%0d want=%0d", cnt_total, exp_total); end
  endtask

  task automatic test_escalation();
    obs_t o; exp_t e;
    e = model(100, 8, 4'd7);
    run_image(100, 8, 4'd7, 0, o);
    exp_total = sat_inc(exp_total); exp_esc = sat_inc(exp_esc);
    checks++; if (o.n_start !== 1) begin errors++; $display("FAIL esc_start_pulses got=%0d want=1", o.n_start); end
    checks++; if (o.cls !== e.cls || o.src !== e.src || o.tmo !== e.tmo) begin errors++; $display("FAIL esc_class got=%0d/%b/%b want=%0d/%b/%b", o.cls, o.src, o.tmo, e.cls, e.src, e.tmo); end
    checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL esc_latency got=%0d want=%0d", o.lat, e.lat); end
    checks++; if (cnt_escalated !== 4'(exp_esc)) begin errors++; $display("FAIL esc_cnt got=%0d want=%0d", cnt_escalated, exp_esc); end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    e = model(-10, -1, 4'd0);
    run_image(-10, -1, 4'd0, 0, o);
    exp_total = sat_inc(exp_total); exp_esc = sat_inc(exp_esc);
    checks++; if (o.lat !== e.lat || o.cls !== e.cls || o.tmo !== 1'b1 || o.src !== 1'b0) begin errors++; $display("FAIL tmo_result got lat=%0d cls=%0d tmo=%b src=%b want %0d/%0d/1/0", o.lat, o.cls, o.tmo, o.src, e.lat, e.cls); end
    checks++; if (!o.ok_after || out_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear got ok=%b tmo=%b want 1/0", o.ok_after, out_timeout); end
    e = model(-10, TMO, 4'd5);
    run_image(-10, TMO, 4'd5, 0, o);
    exp_total = sat_inc(exp_total); exp_esc = sat_inc(exp_esc);
    checks++; if (o.lat !== e.lat || o.cls !== 4'd5 || o.tmo !== 1'b0 || o.src !== 1'b1) begin errors++; $display("FAIL tmo_done_wins got lat=%0d cls=%0d tmo=%b src=%b want %0d/5/0/1", o.lat, o.cls, o.tmo, o.src, e.lat); end
    checks++; if (cnt_total !== 4'(exp_total) || cnt_escalated !== 4'(exp_esc)) begin errors++; $display("FAIL tmo_cnts got=%0d/%0d want=%0d/%0d", cnt_total, cnt_escalated, exp_total, exp_esc); end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    int dec, d, hold;
    logic [3:0] c;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       dec = int'($urandom_range(0, 65535)) - 32768;
        1:       dec = ($urandom_range(0, 1) ? 1 : -1) * int'($urandom_range(250, 262));
        2:       dec = int'($urandom_range(0, 510)) - 255;
        default: dec = ($urandom_range(0, 1) ? -32768 : 32767);
      endcase
      d    = int'($urandom_range(0, TMO + 3)) - 1;
      hold = int'($urandom_range(0, 3));
      c    = 4'($urandom);
      e = model(dec, d, c);
      run_image(dec, d, c, hold, o);
      exp_total = sat_inc(exp_total);
      if (e.esc) exp_esc = sat_inc(exp_esc);
      checks++;
      if (o.lat !== e.lat || o.n_start !== e.n_start || o.cls !== e.cls || o.src !== e.src || o.tmo !== e.tmo)
        begin errors++; $display("FAIL rand_result dec=%0d d=%0d got lat=%0d st=%0d cls=%0d src=%b tmo=%b want %0d/%0d/%0d/%b/%b",
          dec, d, o.lat, o.n_start, o.cls, o.src, o.tmo, e.lat, e.n_start, e.cls, e.src, e.tmo); end
      checks++;
      if (!o.stable || o.nvalid !== hold + 1 || !o.ok_after || cnt_total !== 4'(exp_total) || cnt_escalated !== 4'(exp_esc))
        begin errors++; $display("FAIL rand_hold_cnt dec=%0d got stable=%b nv=%0d ok=%b cnt=%0d/%0d want 1/%0d/1/%0d/%0d",
          dec, o.stable, o.nvalid, o.ok_after, cnt_total, cnt_escalated, hold + 1, exp_total, exp_esc); end
    end
  endtask

  task automatic test_saturation();
    obs_t o;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      run_image((n % 2) ? 1000 : -700, -1, 4'd0, 0, o);
      exp_total = sat_inc(exp_total);
    end
    checks++; if (cnt_total !== 4'd15 || exp_total != 15) begin errors++; $display("FAIL sat_total got=%0d want=15", cnt_total); end
    for (int n = 0; n < 4; n++) begin
      s2_done = 1'b1; s2_class = 4'($urandom);
      step();
    end
    s2_done = 1'b0;
    step();
    checks++; if (cnt_total !== 4'd15 || cnt_escalated !== 4'd0 || out_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL stray_done got cnt=%0d/%0d valid=%b busy=%b want 15/0/0/0", cnt_total, cnt_escalated, out_valid, busy); end
  endtask

  task automatic test_reset_mid_wait();
    bit bad;
    do_reset();
    s1_dec = 16'd50; s1_valid = 1'b1;
    step();
    s1_valid = 1'b0;
    for (int n = 0; n < 6; n++) step();
    checks++; if (busy !== 1'b1 || cnt_escalated !== 4'd1) begin errors++; $display("FAIL pre_rst_wait got busy=%b esc=%0d want 1/1", busy, cnt_escalated); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || cnt_escalated !== 4'd0 || out_valid !== 1'b0 || s2_start !== 1'b0)
      begin errors++; $display("FAIL async_rst got busy=%b esc=%0d valid=%b start=%b want 0/0/0/0", busy, cnt_escalated, out_valid, s2_start); end
    step();
    rst = 1'b0;
    s2_done = 1'b1; s2_class = 4'd9;
    step();
    s2_done = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (out_valid || s2_start || busy) bad = 1'b1;
      step();
    end
    checks++; if (bad || s1_ready !== 1'b1) begin errors++; $display("FAIL late_done_ignored got activity=%b s1_ready=%b want 0/1", bad, s1_ready); end
    checks++; if (cnt_total !== 4'd0 || cnt_escalated !== 4'd0 || out_class !== 4'd0 || out_src !== 1'b0 || out_timeout !== 1'b0)
      begin errors++; $display("FAIL post_rst_state got cnt=%0d/%0d cls=%0d src=%b tmo=%b want 0/0/0/0/0", cnt_total, cnt_escalated, out_class, out_src, out_timeout); end
  endtask

  initial begin
    test_reset();
    test_confident_pos();
    test_confident_neg_backpressure();
    test_escalation();
    test_timeout();
    test_random();
    test_saturation();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
